// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store request stage.
package lsu_pkg;

    // Access width encodings as they arrive on req_size (3 is illegal).
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Byte-lane enable inside the addressed word.
    function automatic logic [3:0] lane_mask(mem_size_e size, logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // True when the request must be answered with an error and no memory access.
    function automatic logic req_illegal(logic [1:0] size, logic [1:0] off);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            2'd2:    return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_req_if.sv
// EXU request/response handshake plus the memory-controller bus of the LSU stage.
interface lsu_mem_req_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_valid;
    logic        mem_wen;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_rdata;

    // The LSU stage itself.
    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
    );

    // The surroundings: EXU on one side, memory controller on the other.
    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half/word out of the memory word and sign- or
// zero-extends it to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  mem_size_e   size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic        sext;

    // Shift the addressed lane down to bit 0, then extend by access size.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        shifted = rdata_i >> {off_i, 3'b000};
        sext    = !unsigned_i;
        data_o  = shifted;
        case (size_i)
            SZ_B:    data_o = {{24{sext & shifted[7]}}, shifted[7:0]};
            SZ_H:    data_o = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_req.sv
// Load/store request stage in front of the memory controller. Takes one
// byte/half/word access from EXU, issues a single word-aligned memory access
// held for MEM_LAT cycles, and returns the extended load data or an error.
module lsu_mem_req
    import lsu_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int XLEN    = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    lsu_mem_req_if.slave bus
);

    localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    lsu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;

    // Request fields the load extractor needs after acceptance.
    logic             store_q;
    mem_size_e        size_q;
    logic             unsigned_q;
    logic [1:0]       off_q;

    // Registered memory-side outputs.
    logic             mem_valid_q;
    logic             mem_wen_q;
    logic [XLEN-1:0]  mem_addr_q;
    logic [XLEN-1:0]  mem_wdata_q;
    logic [3:0]       mem_lane_q;

    // Registered response outputs.
    logic             resp_valid_q;
    logic             resp_err_q;
    logic [XLEN-1:0]  resp_rdata_q;

    logic [XLEN-1:0]  load_data;
    logic [1:0]       req_off;
    logic             req_bad;

    assign req_off = bus.req_addr[1:0];
    assign req_bad = req_illegal(bus.req_size, req_off);

    lsu_load_align u_load_align (
        .rdata_i    (bus.mem_rdata),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (load_data)
    );

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_wen    = mem_wen_q;
    assign bus.mem_raddr  = mem_addr_q;
    assign bus.mem_waddr  = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wmask  = {4'b0000, mem_lane_q};

    // Request FSM: accept in IDLE, hold the access for MEM_LAT cycles, then
    // present the response until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset too, because they drive the memory bus and response port directly and must read 0 out of reset.
            state_q      <= IDLE;
            cnt_q        <= '0;
            store_q      <= 1'b0;
            size_q       <= SZ_B;
            unsigned_q   <= 1'b0;
            off_q        <= 2'b00;
            mem_valid_q  <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_lane_q   <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register sees the pre-edge values.
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (req_bad) begin
                            // Misaligned or illegal size: answer at once, never touch memory.
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state_q      <= RESP;
                        end else begin
                            store_q      <= bus.req_store;
                            size_q       <= mem_size_e'(bus.req_size);
                            unsigned_q   <= bus.req_unsigned;
                            off_q        <= req_off;
                            cnt_q        <= CNT_INIT;
                            mem_valid_q  <= 1'b1;
                            mem_wen_q    <= bus.req_store;
                            mem_addr_q   <= {bus.req_addr[31:2], 2'b00};
                            mem_wdata_q  <= bus.req_wdata << {req_off, 3'b000};
                            mem_lane_q   <= lane_mask(mem_size_e'(bus.req_size), req_off);
                            state_q      <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        // Last access cycle: capture the read word and release the bus.
                        mem_valid_q  <= 1'b0;
                        mem_wen_q    <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_wdata_q  <= '0;
                        mem_lane_q   <= 4'b0000;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= store_q ? '0 : load_data;
                        state_q      <= RESP;
                    end
                end

                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        state_q      <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_req.sv
// Bench for lsu_mem_req: one instance with MEM_LAT=1 and one with MEM_LAT=3,
// driven one at a time through a shared stimulus path, checked against a
// scoreboard of expected responses plus a memory-bus monitor.
module tb_lsu_mem_req;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_mem_req_if bus1();
    lsu_mem_req_if bus3();

    lsu_mem_req #(.MEM_LAT(1), .XLEN(32)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    lsu_mem_req #(.MEM_LAT(3), .XLEN(32)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // Stimulus shared by both instances; sel picks the one being exercised.
    logic        sel;
    logic        t_req_valid, t_req_store, t_req_unsigned, t_resp_ready;
    logic [1:0]  t_req_size;
    logic [31:0] t_req_addr, t_req_wdata, t_mem_rdata;

    assign bus1.req_valid    = t_req_valid & ~sel;
    assign bus3.req_valid    = t_req_valid & sel;
    assign bus1.resp_ready   = t_resp_ready & ~sel;
    assign bus3.resp_ready   = t_resp_ready & sel;
    assign bus1.req_store    = t_req_store;
    assign bus3.req_store    = t_req_store;
    assign bus1.req_size     = t_req_size;
    assign bus3.req_size     = t_req_size;
    assign bus1.req_unsigned = t_req_unsigned;
    assign bus3.req_unsigned = t_req_unsigned;
    assign bus1.req_addr     = t_req_addr;
    assign bus3.req_addr     = t_req_addr;
    assign bus1.req_wdata    = t_req_wdata;
    assign bus3.req_wdata    = t_req_wdata;
    assign bus1.mem_rdata    = t_mem_rdata;
    assign bus3.mem_rdata    = t_mem_rdata;

    // Outputs of the selected instance.
    logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_valid, o_mem_wen;
    logic [31:0] o_resp_rdata, o_mem_raddr, o_mem_waddr, o_mem_wdata;
    logic [7:0]  o_mem_wmask;
    assign o_req_ready  = sel ? bus3.req_ready  : bus1.req_ready;
    assign o_resp_valid = sel ? bus3.resp_valid : bus1.resp_valid;
    assign o_resp_err   = sel ? bus3.resp_err   : bus1.resp_err;
    assign o_resp_rdata = sel ? bus3.resp_rdata : bus1.resp_rdata;
    assign o_mem_valid  = sel ? bus3.mem_valid  : bus1.mem_valid;
    assign o_mem_wen    = sel ? bus3.mem_wen    : bus1.mem_wen;
    assign o_mem_raddr  = sel ? bus3.mem_raddr  : bus1.mem_raddr;
    assign o_mem_waddr  = sel ? bus3.mem_waddr  : bus1.mem_waddr;
    assign o_mem_wdata  = sel ? bus3.mem_wdata  : bus1.mem_wdata;
    assign o_mem_wmask  = sel ? bus3.mem_wmask  : bus1.mem_wmask;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard of expected responses.
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    // Memory-bus monitor, sampled on the falling edge.
    int          mv_cycles = 0, mv_rises = 0, mv_writes = 0, stab_viol = 0, zero_viol = 0;
    logic        prev_mv = 1'b0;
    logic        last_wen = 1'b0;
    logic [31:0] last_raddr = '0, last_waddr = '0, last_wdata = '0;
    logic [7:0]  last_wmask = '0;

    always @(negedge clk) begin
        if (o_mem_valid === 1'b1) begin
            mv_cycles++;
            if (!prev_mv) begin
                mv_rises++;
                if (o_mem_wen === 1'b1) mv_writes++;
            end else if (o_mem_raddr !== last_raddr || o_mem_waddr !== last_waddr ||
                         o_mem_wdata !== last_wdata || o_mem_wmask !== last_wmask ||
                         o_mem_wen !== last_wen) begin
                stab_viol++;
            end
            last_raddr = o_mem_raddr;
            last_waddr = o_mem_waddr;
            last_wdata = o_mem_wdata;
            last_wmask = o_mem_wmask;
            last_wen   = o_mem_wen;
        end else if (o_mem_wen !== 1'b0 || o_mem_raddr !== '0 || o_mem_waddr !== '0 ||
                     o_mem_wdata !== '0 || o_mem_wmask !== '0) begin
            zero_viol++;
        end
        prev_mv = (o_mem_valid === 1'b1);
    end

    task automatic mon_clear();
        mv_cycles = 0;
        mv_rises  = 0;
        mv_writes = 0;
    endtask

    // One complete transaction on the selected instance. The response is left
    // waiting for 'hold' cycles with a competing request asserted, then taken.
    task automatic do_op(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int hold,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int held_bad);
        int w;
        t_resp_ready = 1'b0;
        @(negedge clk);
        mon_clear();
        t_req_valid    = 1'b1;
        t_req_store    = st;
        t_req_size     = sz;
        t_req_unsigned = uns;
        t_req_addr     = addr;
        t_req_wdata    = wd;
        w = 0;
        while (o_req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        // Scramble the request fields: they must have been captured already.
        t_req_valid    = 1'b0;
        t_req_store    = 1'($urandom);
        t_req_unsigned = 1'($urandom);
        t_req_size     = 2'($urandom);
        t_req_addr     = $urandom;
        t_req_wdata    = $urandom;
        lat = 1;
        while (o_resp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = o_resp_rdata;
        er = o_resp_err;
        held_bad = 0;
        for (int k = 0; k < hold; k++) begin
            t_req_valid = 1'b1;
            @(negedge clk);
            if (o_resp_valid !== 1'b1 || o_resp_rdata !== rd || o_resp_err !== er ||
                o_req_ready !== 1'b0) held_bad++;
        end
        t_req_valid  = 1'b0;
        t_resp_ready = 1'b1;
        @(negedge clk);
        t_resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        if ({bus1.req_ready, bus1.resp_valid, bus1.resp_err, bus1.mem_valid, bus1.mem_wen} !== 5'b10000) begin
            $display("FAIL reset_ctrl_lat1: got %b expected 10000",
                     {bus1.req_ready, bus1.resp_valid, bus1.resp_err, bus1.mem_valid, bus1.mem_wen});
        end else n_pass++;
        n_checks++;
        if ({bus3.req_ready, bus3.resp_valid, bus3.resp_err, bus3.mem_valid, bus3.mem_wen} !== 5'b10000) begin
            $display("FAIL reset_ctrl_lat3: got %b expected 10000",
                     {bus3.req_ready, bus3.resp_valid, bus3.resp_err, bus3.mem_valid, bus3.mem_wen});
        end else n_pass++;
        n_checks++;
        if ({bus1.resp_rdata, bus1.mem_raddr, bus1.mem_waddr, bus1.mem_wdata, bus1.mem_wmask} !== '0) begin
            $display("FAIL reset_data: rdata=%h raddr=%h waddr=%h wdata=%h wmask=%h expected all 0",
                     bus1.resp_rdata, bus1.mem_raddr, bus1.mem_waddr, bus1.mem_wdata, bus1.mem_wmask);
        end else n_pass++;
        n_checks++;
    endtask

    task automatic test_lw();
        logic [31:0] rd; logic er; int lat, hb; exp_t e;
        sel = 1'b0;
        t_mem_rdata = 32'hDEAD_BEEF;
        sb_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
        do_op(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, 0, rd, er, lat, hb);
        e = sb_q.pop_front();
        if ({rd, er} !== {e.rdata, e.err}) $display("FAIL lw_data: got %h/%b expected %h/%b", rd, er, e.rdata, e.err);
        else n_pass++;
        n_checks++;
        if (lat !== 2) $display("FAIL lw_latency: got %0d expected 2", lat);
        else n_pass++;
        n_checks++;
        if (mv_cycles !== 1 || mv_rises !== 1) $display("FAIL lw_mem_valid: got %0d cycles/%0d rises expected 1/1", mv_cycles, mv_rises);
        else n_pass++;
        n_checks++;
        if (last_raddr !== 32'h8000_0004 || last_wen !== 1'b0)
            $display("FAIL lw_raddr: got %h wen=%b expected 80000004 wen=0", last_raddr, last_wen);
        else n_pass++;
        n_checks++;
        if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1)
            $display("FAIL lw_handshake: got resp_valid=%b req_ready=%b expected 0/1", o_resp_valid, o_req_ready);
        else n_pass++;
        n_checks++;
    endtask

    typedef struct packed {
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic [7:0]  exp_mask;
    } ld_vec_t;

    task automatic test_load_extend();
        ld_vec_t v [6];
        logic [31:0] rd; logic er; int lat, hb; exp_t e;
        v[0] = '{size: 2'd0, uns: 1'b0, addr: 32'h8000_0007, exp_data: 32'hFFFF_FF80, exp_mask: 8'h08};
        v[1] = '{size: 2'd0, uns: 1'b1, addr: 32'h8000_0007, exp_data: 32'h0000_0080, exp_mask: 8'h08};
        v[2] = '{size: 2'd1, uns: 1'b0, addr: 32'h8000_0002, exp_data: 32'hFFFF_80FF, exp_mask: 8'h0C};
        v[3] = '{size: 2'd1, uns: 1'b1, addr: 32'h8000_0002, exp_data: 32'h0000_80FF, exp_mask: 8'h0C};
        v[4] = '{size: 2'd0, uns: 1'b0, addr: 32'h8000_0006, exp_data: 32'hFFFF_FFFF, exp_mask: 8'h04};
        v[5] = '{size: 2'd1, uns: 1'b0, addr: 32'h8000_0000, exp_data: 32'h0000_0000, exp_mask: 8'h03};
        sel = 1'b0;
        t_mem_rdata = 32'h80FF_0000;
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back('{rdata: v[i].exp_data, err: 1'b0});
            do_op(1'b0, v[i].size, v[i].uns, v[i].addr, 32'h0, 0, rd, er, lat, hb);
            e = sb_q.pop_front();
            if ({rd, er} !== {e.rdata, e.err})
                $display("FAIL load_ext_%0d: got %h/%b expected %h/%b", i, rd, er, e.rdata, e.err);
            else n_pass++;
            n_checks++;
            if (last_wmask !== v[i].exp_mask || last_raddr !== {v[i].addr[31:2], 2'b00})
                $display("FAIL load_lane_%0d: got mask %h addr %h expected %h %h",
                         i, last_wmask, last_raddr, v[i].exp_mask, {v[i].addr[31:2], 2'b00});
            else n_pass++;
            n_checks++;
        end
    endtask

    typedef struct packed {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_wdata;
        logic [7:0]  exp_mask;
    } st_vec_t;

    task automatic test_store();
        st_vec_t v [4];
        logic [31:0] rd; logic er; int lat, hb; exp_t e;
        v[0] = '{size: 2'd0, addr: 32'h8000_0003, wd: 32'h0000_00AB, exp_wdata: 32'hAB00_0000, exp_mask: 8'h08};
        v[1] = '{size: 2'd1, addr: 32'h8000_0002, wd: 32'h0000_1234, exp_wdata: 32'h1234_0000, exp_mask: 8'h0C};
        v[2] = '{size: 2'd2, addr: 32'h8000_0008, wd: 32'h1234_5678, exp_wdata: 32'h1234_5678, exp_mask: 8'h0F};
        v[3] = '{size: 2'd0, addr: 32'h8000_0011, wd: 32'h0000_00CD, exp_wdata: 32'h0000_CD00, exp_mask: 8'h02};
        sel = 1'b0;
        t_mem_rdata = 32'h5A5A_5A5A;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{rdata: 32'h0, err: 1'b0});
            do_op(1'b1, v[i].size, 1'b0, v[i].addr, v[i].wd, 0, rd, er, lat, hb);
            e = sb_q.pop_front();
            if ({rd, er} !== {e.rdata, e.err})
                $display("FAIL store_resp_%0d: got %h/%b expected %h/%b", i, rd, er, e.rdata, e.err);
            else n_pass++;
            n_checks++;
            if (mv_writes !== 1 || last_wen !== 1'b1 || last_wmask !== v[i].exp_mask)
                $display("FAIL store_ctrl_%0d: got writes=%0d wen=%b mask=%h expected 1/1/%h",
                         i, mv_writes, last_wen, last_wmask, v[i].exp_mask);
            else n_pass++;
            n_checks++;
            if (last_wdata !== v[i].exp_wdata || last_waddr !== {v[i].addr[31:2], 2'b00})
                $display("FAIL store_data_%0d: got wdata=%h waddr=%h expected %h %h",
                         i, last_wdata, last_waddr, v[i].exp_wdata, {v[i].addr[31:2], 2'b00});
            else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_errors();
        logic [1:0]  sz [4];
        logic [31:0] ad [4];
        logic        st [4];
        logic [31:0] rd; logic er; int lat, hb; exp_t e;
        sz[0] = 2'd2; ad[0] = 32'h8000_0002; st[0] = 1'b0;
        sz[1] = 2'd3; ad[1] = 32'h8000_0000; st[1] = 1'b0;
        sz[2] = 2'd1; ad[2] = 32'h8000_0001; st[2] = 1'b1;
        sz[3] = 2'd2; ad[3] = 32'h8000_0003; st[3] = 1'b1;
        sel = 1'b0;
        t_mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{rdata: 32'h0, err: 1'b1});
            do_op(st[i], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF, 0, rd, er, lat, hb);
            e = sb_q.pop_front();
            if ({rd, er} !== {e.rdata, e.err})
                $display("FAIL err_resp_%0d: got %h/%b expected %h/%b", i, rd, er, e.rdata, e.err);
            else n_pass++;
            n_checks++;
            if (mv_rises !== 0 || lat !== 1)
                $display("FAIL err_no_access_%0d: got rises=%0d latency=%0d expected 0/1", i, mv_rises, lat);
            else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat, hb; exp_t e;
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            t_mem_rdata = 32'h1111_0000 + 32'(i) * 32'h0101_0101;
            sb_q.push_back('{rdata: 32'h1111_0000 + 32'(i) * 32'h0101_0101, err: 1'b0});
            do_op(1'b0, 2'd2, 1'b0, 32'h8000_0100 + 32'(i) * 32'd4, 32'h0, 0, rd, er, lat, hb);
            e = sb_q.pop_front();
            if ({rd, er} !== {e.rdata, e.err} || mv_rises !== 1)
                $display("FAIL b2b_%0d: got %h/%b rises=%0d expected %h/%b rises=1", i, rd, er, mv_rises, e.rdata, e.err);
            else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_latency3();
        logic [31:0] rd; logic er; int lat, hb; exp_t e;
        sel = 1'b1;
        t_mem_rdata = 32'h1357_9BDF;
        sb_q.push_back('{rdata: 32'h1357_9BDF, err: 1'b0});
        do_op(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 5, rd, er, lat, hb);
        e = sb_q.pop_front();
        if ({rd, er} !== {e.rdata, e.err}) $display("FAIL lat3_data: got %h/%b expected %h/%b", rd, er, e.rdata, e.err);
        else n_pass++;
        n_checks++;
        if (lat !== 4 || mv_cycles !== 3)
            $display("FAIL lat3_timing: got latency=%0d mem_valid_cycles=%0d expected 4/3", lat, mv_cycles);
        else n_pass++;
        n_checks++;
        if (hb !== 0) $display("FAIL lat3_hold: got %0d unstable cycles expected 0", hb);
        else n_pass++;
        n_checks++;
        repeat (2) @(negedge clk);
        if (mv_rises !== 1 || o_req_ready !== 1'b1)
            $display("FAIL lat3_no_early_accept: got rises=%0d req_ready=%b expected 1/1", mv_rises, o_req_ready);
        else n_pass++;
        n_checks++;
        sb_q.push_back('{rdata: 32'h0, err: 1'b0});
        do_op(1'b1, 2'd0, 1'b0, 32'h8000_0021, 32'h0000_0077, 0, rd, er, lat, hb);
        e = sb_q.pop_front();
        if ({rd, er} !== {e.rdata, e.err} || mv_writes !== 1 || mv_cycles !== 3 || last_wmask !== 8'h02)
            $display("FAIL lat3_store: got %h/%b writes=%0d cycles=%0d mask=%h expected 0/0 1 3 02",
                     rd, er, mv_writes, mv_cycles, last_wmask);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat, hb; exp_t e;
        sel = 1'b1;
        t_mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        t_req_valid = 1'b1; t_req_store = 1'b0; t_req_size = 2'd2; t_req_unsigned = 1'b0;
        t_req_addr  = 32'h8000_0040; t_req_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        t_req_valid = 1'b0;
        if (o_mem_valid !== 1'b1) $display("FAIL abort_in_access: got mem_valid=%b expected 1", o_mem_valid);
        else n_pass++;
        n_checks++;
        #2 rst_n = 1'b0;
        #1;
        if ({o_mem_valid, o_resp_valid, o_mem_wen} !== 3'b000)
            $display("FAIL abort_async: got mem_valid/resp_valid/wen=%b expected 000", {o_mem_valid, o_resp_valid, o_mem_wen});
        else n_pass++;
        n_checks++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0)
            $display("FAIL abort_idle: got req_ready=%b resp_valid=%b expected 1/0", o_req_ready, o_resp_valid);
        else n_pass++;
        n_checks++;
        sb_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
        do_op(1'b0, 2'd2, 1'b0, 32'h8000_0044, 32'h0, 0, rd, er, lat, hb);
        e = sb_q.pop_front();
        if ({rd, er} !== {e.rdata, e.err} || lat !== 4)
            $display("FAIL abort_recover: got %h/%b latency=%0d expected %h/%b latency=4", rd, er, lat, e.rdata, e.err);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_bus_hygiene();
        if (stab_viol !== 0 || zero_viol !== 0)
            $display("FAIL bus_hygiene: got %0d unstable and %0d non-zero idle samples expected 0/0", stab_viol, zero_viol);
        else n_pass++;
        n_checks++;
        if (sb_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        else n_pass++;
        n_checks++;
    endtask

    initial begin
        sel = 1'b0;
        t_req_valid = 1'b0; t_req_store = 1'b0; t_req_unsigned = 1'b0; t_resp_ready = 1'b0;
        t_req_size = 2'd0; t_req_addr = '0; t_req_wdata = '0; t_mem_rdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_lw();
        test_load_extend();
        test_store();
        test_errors();
        test_back_to_back();
        test_latency3();
        test_reset_abort();
        test_bus_hygiene();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
